// File: rtl/sync_packet_framer.sv
// sync_packet_framer: buffers one packet of 16-bit words, then emits it as a
// framed stream of 9-bit symbols into the sync or async TX symbol FIFO.
// Frame: K_START, seq, length, payload bytes (MSB first), CRC-8, K_END.
module sync_packet_framer #(
  parameter int         MAX_WORDS = 16,
  parameter logic [8:0] K_START   = 9'h1FB,
  parameter logic [8:0] K_END     = 9'h1FD,
  parameter logic [7:0] CRC_POLY  = 8'h07
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [15:0] in_data_i,
  input  logic        in_last_i,
  input  logic        in_async_i,
  input  logic [1:0]  fifo_afull_i,
  output logic [8:0]  sym_o,
  output logic [1:0]  sym_we_o,
  output logic        busy_o,
  output logic        pkt_done_o,
  output logic        overflow_o,
  output logic [7:0]  seq_o
);

  localparam int         IW      = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam logic [7:0] MAX_CNT = 8'(MAX_WORDS);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_LOAD   = 4'd1;
  localparam logic [3:0] S_DROP   = 4'd2;
  localparam logic [3:0] S_START  = 4'd3;
  localparam logic [3:0] S_SEQ    = 4'd4;
  localparam logic [3:0] S_LEN    = 4'd5;
  localparam logic [3:0] S_PAY_HI = 4'd6;
  localparam logic [3:0] S_PAY_LO = 4'd7;
  localparam logic [3:0] S_CRC    = 4'd8;
  localparam logic [3:0] S_END    = 4'd9;

  logic [1:0]  rst_sync_q, rst_sync_d;
  logic        rst_n;
  logic [3:0]  state_q, state_d;
  logic [7:0]  count_q, count_d;
  logic [7:0]  rd_idx_q, rd_idx_d;
  logic [7:0]  seq_q, seq_d;
  logic [7:0]  crc_q, crc_d;
  logic        class_q, class_d;
  logic [15:0] mem_q [MAX_WORDS];
  logic        mem_we;
  logic [IW-1:0] mem_addr;
  logic        accepting;
  logic        handshake;
  logic        sym_wr;
  logic [15:0] rd_word;
  logic [8:0]  sym;

  // One step of MSB-first CRC-8 over a whole byte, no reflection.
  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  // Reset is asserted asynchronously but released only after two clean clock edges.
  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rst_sync_q <= 2'b00;
    else         rst_sync_q <= rst_sync_d;
  end
  assign rst_n = rst_sync_q[1];

  // Handshake, stall and symbol selection for the current state.
  always_comb begin
    accepting = (state_q == S_IDLE) || (state_q == S_LOAD) || (state_q == S_DROP);
    in_ready_o = rst_n & accepting;
    handshake  = in_valid_i & in_ready_o;
    sym_wr     = ~accepting & ~fifo_afull_i[class_q];
    rd_word    = mem_q[rd_idx_q[IW-1:0]];
    sym        = 9'h000;
    case (state_q)
      S_START:  sym = K_START;
      S_SEQ:    sym = {1'b0, seq_q};
      S_LEN:    sym = {1'b0, count_q};
      S_PAY_HI: sym = {1'b0, rd_word[15:8]};
      S_PAY_LO: sym = {1'b0, rd_word[7:0]};
      S_CRC:    sym = {1'b0, crc_q};
      S_END:    sym = K_END;
      default:  sym = 9'h000;
    endcase
  end

  assign sym_o      = sym;
  assign sym_we_o   = sym_wr ? (class_q ? 2'b10 : 2'b01) : 2'b00;
  assign pkt_done_o = sym_wr && (state_q == S_END);
  assign busy_o     = !((state_q == S_IDLE) && (count_q == 8'd0));
  assign seq_o      = seq_q;

  // Next-state logic: load/drop words, then walk the frame one symbol per write.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rd_idx_d   = rd_idx_q;
    seq_d      = seq_q;
    crc_d      = crc_q;
    class_d    = class_q;
    mem_we     = 1'b0;
    mem_addr   = count_q[IW-1:0];
    overflow_o = 1'b0;
    case (state_q)
      S_IDLE: if (handshake) begin
        mem_we   = 1'b1;
        mem_addr = '0;
        class_d  = in_async_i;
        count_d  = 8'd1;
        state_d  = in_last_i ? S_START : S_LOAD;
      end
      S_LOAD: if (handshake) begin
        mem_we  = 1'b1;
        count_d = count_q + 8'd1;
        if (in_last_i)                      state_d = S_START;
        else if (count_q + 8'd1 == MAX_CNT) state_d = S_DROP;
      end
      S_DROP: if (handshake) begin
        overflow_o = 1'b1;
        if (in_last_i) state_d = S_START;
      end
      S_START: if (sym_wr) begin
        crc_d    = 8'h00;
        rd_idx_d = 8'd0;
        state_d  = S_SEQ;
      end
      S_SEQ: if (sym_wr) begin
        crc_d   = crc8_next(crc_q, sym[7:0]);
        state_d = S_LEN;
      end
      S_LEN: if (sym_wr) begin
        crc_d   = crc8_next(crc_q, sym[7:0]);
        state_d = S_PAY_HI;
      end
      S_PAY_HI: if (sym_wr) begin
        crc_d   = crc8_next(crc_q, sym[7:0]);
        state_d = S_PAY_LO;
      end
      S_PAY_LO: if (sym_wr) begin
        crc_d    = crc8_next(crc_q, sym[7:0]);
        rd_idx_d = rd_idx_q + 8'd1;
        state_d  = (rd_idx_q + 8'd1 == count_q) ? S_CRC : S_PAY_HI;
      end
      S_CRC: if (sym_wr) state_d = S_END;
      S_END: if (sym_wr) begin
        seq_d   = seq_q + 8'd1;
        count_d = 8'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers; any reset abandons a partially loaded or emitted packet.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      count_q  <= 8'd0;
      rd_idx_q <= 8'd0;
      seq_q    <= 8'd0;
      crc_q    <= 8'h00;
      class_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_idx_q <= rd_idx_d;
      seq_q    <= seq_d;
      crc_q    <= crc_d;
      class_q  <= class_d;
    end
  end

  // Packet buffer; contents are meaningless until count says otherwise, so no reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[mem_addr] <= in_data_i;
  end

endmodule

// File: tb/tb_sync_packet_framer.sv
// Self-checking bench for sync_packet_framer: a model builds each expected
// frame into a scoreboard queue as the packet is driven; a negedge monitor
// pops and compares every symbol the DUT writes.
module tb_sync_packet_framer;

   localparam int         MW     = 16;
   localparam logic [8:0] KSTART = 9'h1FB;
   localparam logic [8:0] KEND   = 9'h1FD;

   typedef struct packed {
      logic [8:0] sym;
      logic [1:0] we;
   } sbEntry;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   logic [15:0] in_data_i = 16'h0;
   logic        in_last_i = 1'b0;
   logic        in_async_i = 1'b0;
   logic [1:0]  fifo_afull_i = 2'b00;
   logic [8:0]  sym_o;
   logic [1:0]  sym_we_o;
   logic        busy_o;
   logic        pkt_done_o;
   logic        overflow_o;
   logic [7:0]  seq_o;

   int          nChecks = 0;
   int          nFail = 0;
   int          symsSeen = 0;
   int          ovfSeen = 0;
   int          expOvf = 0;
   int          cyc = 0;
   int          lastEndCyc = 0;
   bit          lastEndValid = 1'b0;
   bit          gapCheck = 1'b0;
   logic [7:0]  expSeq = 8'h00;
   logic [15:0] pktWords [$];
   sbEntry      sb [$];

   sync_packet_framer #(.MAX_WORDS(MW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .in_data_i(in_data_i), .in_last_i(in_last_i), .in_async_i(in_async_i),
      .fifo_afull_i(fifo_afull_i),
      .sym_o(sym_o), .sym_we_o(sym_we_o), .busy_o(busy_o),
      .pkt_done_o(pkt_done_o), .overflow_o(overflow_o), .seq_o(seq_o)
   );

   // Free-running 100 MHz clock.
   always #5 clk_i = ~clk_i;

   // Cycle counter used to measure gaps between frames.
   always @(posedge clk_i) cyc <= cyc + 1;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Bit-serial reference CRC-8 (poly 0x07, MSB first, init 0).
   function automatic logic [7:0] refCrc(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      logic       fb;
      c = crc;
      for (int i = 7; i >= 0; i--) begin
         fb = c[7] ^ data[i];
         c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
      return c;
   endfunction

   function automatic void pushSym(input logic [8:0] s, input logic [1:0] w);
      sbEntry e;
      e.sym = s;
      e.we  = w;
      sb.push_back(e);
   endfunction

   // Monitor: every DUT write must match the head of the scoreboard.
   always @(negedge clk_i) begin
      if (!rst_ni) begin
         lastEndValid <= 1'b0;
      end else begin
         if (overflow_o) ovfSeen++;
         if (sym_we_o != 2'b00) begin
            checkOutput("we_onehot", {30'd0, sym_we_o}, (sym_we_o[0] ? 32'd1 : 32'd2));
            checkOutput("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
               sbEntry e;
               e = sb.pop_front();
               checkOutput("sym", {23'd0, sym_o}, {23'd0, e.sym});
               checkOutput("sym_we", {30'd0, sym_we_o}, {30'd0, e.we});
               checkOutput("pkt_done", {31'd0, pkt_done_o}, {31'd0, e.sym == KEND});
               if (gapCheck && lastEndValid && e.sym == KSTART)
                  checkOutput("b2b_gap", cyc - lastEndCyc, 32'd2);
               if (e.sym == KEND) begin
                  lastEndCyc   <= cyc;
                  lastEndValid <= 1'b1;
               end
            end
            symsSeen++;
         end else if (pkt_done_o) begin
            checkOutput("done_without_write", {31'd0, pkt_done_o}, 32'd0);
         end
      end
   end

   // Build the expected frame for pktWords, then hand the words to the DUT.
   // Later words carry the opposite class bit: only the first word may count.
   task automatic applyStimulus(input bit asyncCls);
      int         n, len, waitCnt;
      logic [7:0] crc;
      logic [1:0] w;
      logic [15:0] d;
      bit         rdy;
      n   = pktWords.size();
      len = (n > MW) ? MW : n;
      w   = asyncCls ? 2'b10 : 2'b01;
      crc = refCrc(8'h00, expSeq);
      crc = refCrc(crc, 8'(len));
      pushSym(KSTART, w);
      pushSym({1'b0, expSeq}, w);
      pushSym({1'b0, 8'(len)}, w);
      for (int i = 0; i < len; i++) begin
         d = pktWords[i];
         pushSym({1'b0, d[15:8]}, w);
         pushSym({1'b0, d[7:0]}, w);
         crc = refCrc(crc, d[15:8]);
         crc = refCrc(crc, d[7:0]);
      end
      pushSym({1'b0, crc}, w);
      pushSym(KEND, w);
      expSeq = expSeq + 8'd1;
      if (n > MW) expOvf += n - MW;
      for (int i = 0; i < n; i++) begin
         in_valid_i = 1'b1;
         in_data_i  = pktWords[i];
         in_last_i  = (i == n - 1);
         in_async_i = (i == 0) ? asyncCls : ~asyncCls;
         waitCnt = 0;
         do begin
            @(negedge clk_i);
            rdy = in_ready_o;
            @(posedge clk_i);
            #1;
            waitCnt++;
         end while (!rdy && waitCnt < 200);
         if (!rdy) checkOutput("hs_ready", {31'd0, rdy}, 32'd1);
      end
      in_valid_i = 1'b0;
      in_last_i  = 1'b0;
   endtask

   task automatic waitSyms(input int target, input int budget);
      int k;
      k = 0;
      while (symsSeen < target && k < budget) begin
         @(posedge clk_i);
         k++;
      end
      if (symsSeen < target) checkOutput("wait_syms", symsSeen, target);
   endtask

   task automatic waitDrain(input int budget);
      int k;
      k = 0;
      while (sb.size() != 0 && k < budget) begin
         @(posedge clk_i);
         k++;
      end
      repeat (2) @(posedge clk_i);
      #1;
      checkOutput("sb_drained", sb.size(), 32'd0);
   endtask

   initial begin
      int base;
      // Reset state
      #3;
      checkOutput("rst_sym", {23'd0, sym_o}, 32'd0);
      checkOutput("rst_we", {30'd0, sym_we_o}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy_o}, 32'd0);
      checkOutput("rst_ready", {31'd0, in_ready_o}, 32'd0);
      checkOutput("rst_seq", {24'd0, seq_o}, 32'd0);
      repeat (3) @(posedge clk_i);
      #1 rst_ni = 1'b1;

      // One-word sync packet, 1FB 000 001 012 034 09A 1FD
      pktWords = '{16'h1234};
      applyStimulus(1'b0);
      waitDrain(100);
      checkOutput("seq_after_1", {24'd0, seq_o}, {24'd0, expSeq});

      // Two-word async packet, sync FIFO almost full is irrelevant
      fifo_afull_i = 2'b01;
      pktWords = '{16'hAABB, 16'hCCDD};
      applyStimulus(1'b1);
      waitDrain(100);
      fifo_afull_i = 2'b00;

      // Sync packet with async FIFO almost full throughout
      fifo_afull_i = 2'b10;
      pktWords = '{16'h0F0F, 16'h8001, 16'h7E55};
      applyStimulus(1'b0);
      waitDrain(100);
      fifo_afull_i = 2'b00;

      // Three-cycle stall during PAY_LO of a sync packet
      base = symsSeen;
      pktWords = '{16'h1234};
      applyStimulus(1'b0);
      waitSyms(base + 4, 50);
      #1 fifo_afull_i = 2'b01;
      repeat (3) begin
         @(negedge clk_i);
         checkOutput("stall_we", {30'd0, sym_we_o}, 32'd0);
         checkOutput("stall_sym", {23'd0, sym_o}, 32'h034);
         checkOutput("stall_busy", {31'd0, busy_o}, 32'd1);
         @(posedge clk_i);
      end
      #1 fifo_afull_i = 2'b00;
      waitDrain(100);

      // Oversized packet: MW+3 words, three dropped
      pktWords.delete();
      for (int i = 0; i < MW + 3; i++) pktWords.push_back(16'($urandom));
      applyStimulus(1'b0);
      waitDrain(200);
      checkOutput("overflow_cnt", ovfSeen, expOvf);

      // Reset while the length symbol is pending
      base = symsSeen;
      pktWords = '{16'h1111, 16'h2222};
      applyStimulus(1'b1);
      waitSyms(base + 2, 50);
      #1 rst_ni = 1'b0;
      #1;
      checkOutput("midrst_sym", {23'd0, sym_o}, 32'd0);
      checkOutput("midrst_we", {30'd0, sym_we_o}, 32'd0);
      checkOutput("midrst_busy", {31'd0, busy_o}, 32'd0);
      checkOutput("midrst_done", {31'd0, pkt_done_o}, 32'd0);
      checkOutput("midrst_ovf", {31'd0, overflow_o}, 32'd0);
      checkOutput("midrst_seq", {24'd0, seq_o}, 32'd0);
      checkOutput("midrst_ready", {31'd0, in_ready_o}, 32'd0);
      sb.delete();
      expSeq = 8'h00;
      repeat (3) @(posedge clk_i);
      #1 rst_ni = 1'b1;

      // 257 back-to-back one-word packets starting at seq 0
      gapCheck = 1'b1;
      for (int p = 0; p < 257; p++) begin
         pktWords = '{16'($urandom)};
         applyStimulus(1'b0);
      end
      waitDrain(100);
      gapCheck = 1'b0;
      checkOutput("seq_wrap", {24'd0, seq_o}, {24'd0, expSeq});

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

   // Absolute watchdog so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
